cmp_sort_ctrl: RTL

- Sequencer that time-shares a single comparator_16b instance to sort a small register file of unsigned 16-bit values in place.
- Uses a bubble sort with early exit.
- The host loads values, pulses start, waits for done, then reads the sorted result back.
- Sits beside comparator_16b as its controlling FSM; it is the only user of that comparator.

---
 rtl/cmp_sort_pkg.sv | 14 +
 rtl/comparator_16b.sv | 15 +
 rtl/cmp_sort_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/cmp_sort_pkg.sv
// Shared types and widths for the comparator-based in-place sorter.
package cmp_sort_pkg;

   localparam int DATA_W    = 16;
   localparam int DEPTH_MAX = 16;
   localparam int PASS_W    = $clog2(DEPTH_MAX);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SCAN   = 2'd1,
      FINISH = 2'd2
   } state_t;

endpackage

// File: rtl/comparator_16b.sv
// Unsigned 16-bit magnitude comparator; purely combinational so the sorter
// can compare and swap a pair within one cycle.
module comparator_16b (
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic        great,
   output logic        less,
   output logic        equal
);

   assign great = (a > b);
   assign less  = (a < b);
   assign equal = (a == b);

endmodule

// File: rtl/cmp_sort_ctrl.sv
// Bubble-sort sequencer (early exit) sharing one comparator_16b over a small
// register file. Define CMP_SORT_SWAP_COUNT_EN to add the swap_count output.
module cmp_sort_ctrl
   import cmp_sort_pkg::*;
#(
   parameter int DEPTH      = 4,
   parameter bit DESCENDING = 1'b0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     start,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [DATA_W-1:0]        rd_data,
   output logic                     busy,
   output logic                     done
`ifdef CMP_SORT_SWAP_COUNT_EN
  ,output logic [7:0]               swap_count
`endif
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem_r [DEPTH];
   state_t            state_r;
   logic [AW-1:0]     j_r;
   logic [AW-1:0]     j_nxt_s;
   logic [PASS_W-1:0] pass_r;
   logic              swapped_r;
   logic              busy_r;
   logic              done_r;
   logic [DATA_W-1:0] a_s;
   logic [DATA_W-1:0] b_s;
   logic              gt_s;
   logic              lt_s;
   logic              eq_s;
   logic              swap_s;
   logic              pass_end_s;
   logic              sort_over_s;
`ifdef CMP_SORT_SWAP_COUNT_EN
   logic [7:0]        swap_count_r;
`endif

   assign j_nxt_s = j_r + AW'(1);

   // Comparator operand select: the current pair in SCAN, entries 0/1 otherwise.
   always_comb begin
      a_s = mem_r[0];
      b_s = mem_r[1];
      if (state_r == SCAN) begin
         a_s = mem_r[j_r];
         b_s = mem_r[j_nxt_s];
      end else begin
         a_s = mem_r[0];
         b_s = mem_r[1];
      end
   end

   comparator_16b u_cmp (
      .a     (a_s),
      .b     (b_s),
      .great (gt_s),
      .less  (lt_s),
      .equal (eq_s)
   );

   // Equal pairs never swap, which keeps the sort stable.
   assign swap_s      = (state_r == SCAN) && !eq_s && (DESCENDING ? lt_s : gt_s);
   assign pass_end_s  = (j_r == AW'(DEPTH - 2));
   assign sort_over_s = !(swapped_r || swap_s) || (pass_r == PASS_W'(DEPTH - 2));

   // Combinational read port, guarded for non-power-of-two depths.
   always_comb begin
      rd_data = '0;
      if (int'(rd_addr) < DEPTH) begin
         rd_data = mem_r[rd_addr];
      end else begin
         rd_data = '0;
      end
   end

   // Sequencer FSM together with register file, counters and status flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
         state_r   <= IDLE;
         j_r       <= '0;
         pass_r    <= '0;
         swapped_r <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               done_r <= 1'b0;
               if (wr_en && (int'(wr_addr) < DEPTH)) begin
                  mem_r[wr_addr] <= wr_data;
               end
               if (start) begin
                  state_r   <= SCAN;
                  j_r       <= '0;
                  pass_r    <= '0;
                  swapped_r <= 1'b0;
                  busy_r    <= 1'b1;
               end
            end
            SCAN: begin
               if (swap_s) begin
                  mem_r[j_r]     <= b_s;
                  mem_r[j_nxt_s] <= a_s;
               end
               if (pass_end_s) begin
                  j_r       <= '0;
                  swapped_r <= 1'b0;
                  if (sort_over_s) begin
                     state_r <= FINISH;
                     done_r  <= 1'b1;
                  end else begin
                     pass_r <= pass_r + PASS_W'(1);
                  end
               end else begin
                  j_r       <= j_nxt_s;
                  swapped_r <= swapped_r | swap_s;
               end
            end
            FINISH: begin
               state_r   <= IDLE;
               done_r    <= 1'b0;
               busy_r    <= 1'b0;
               j_r       <= '0;
               pass_r    <= '0;
               swapped_r <= 1'b0;
            end
            default: begin
               state_r   <= IDLE;
               done_r    <= 1'b0;
               busy_r    <= 1'b0;
               j_r       <= '0;
               pass_r    <= '0;
               swapped_r <= 1'b0;
            end
         endcase
      end
   end

`ifdef CMP_SORT_SWAP_COUNT_EN
   // Saturating count of swaps in the most recent sort.
   always_ff @(posedge clk) begin
      if (rst) begin
         swap_count_r <= 8'd0;
      end else if ((state_r == IDLE) && start) begin
         swap_count_r <= 8'd0;
      end else if (swap_s && (swap_count_r != 8'hFF)) begin
         swap_count_r <= swap_count_r + 8'd1;
      end else begin
         swap_count_r <= swap_count_r;
      end
   end

   assign swap_count = swap_count_r;
`endif

   assign busy = busy_r;
   assign done = done_r;

endmodule
